// File: rtl/psw_code_writer.sv
// Enrolment writer for the switch-password lock: capture a new code, confirm it, commit it.
// Optional three-strike lockout is built when PSW_LOCKOUT_EN is defined.
module psw_code_writer #(
  parameter int CODE_LEN = 4,
  parameter int TIMEOUT = 50000000,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h4321,
  parameter int LOCKOUT_CYCLES = 250000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sw_rise,
  input  logic       enroll_req,
  input  logic       unlocked,
  input  logic [2:0] rd_idx,
  output logic [3:0] rd_digit,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] wr_state
);

  localparam int CNT_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTER   = 3'd1,
    S_CONFIRM = 3'd2,
    S_COMMIT  = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [4*CODE_LEN-1:0]   code_q;
  logic [4*CODE_LEN-1:0]   shadow_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [TMO_W-1:0]        tmo_q;

  logic       key_vld, key_bad, cnt_last, tmo_end;
  logic [3:0] key_digit, shadow_digit;

`ifdef PSW_LOCKOUT_EN
  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  logic [1:0]        fail_cnt_q;
  logic [LOCK_W-1:0] lock_cnt_q;
  logic              lock_end;
  assign lock_end = (lock_cnt_q == LOCK_W'(LOCKOUT_CYCLES - 1));
`endif

  // Key decode: exactly one switch edge is a digit, several at once is a bad key.
  always_comb begin
    key_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (sw_rise[i]) key_digit = 4'(i);
    end
  end

  assign key_vld  = $onehot(sw_rise);
  assign key_bad  = (sw_rise != 10'd0) && !key_vld;
  assign cnt_last = (cnt_q == CNT_W'(CODE_LEN - 1));
  assign tmo_end  = (tmo_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    shadow_digit = 4'd0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (cnt_q == CNT_W'(i)) shadow_digit = shadow_q[4*i +: 4];
    end
  end

  always_comb begin
    rd_digit = 4'd0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (rd_idx == 3'(i)) rd_digit = code_q[4*i +: 4];
    end
  end

  // Next-state decision; a dropped unlock or bad key outranks any digit in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enroll_req && unlocked) state_d = S_ENTER;
      end
      S_ENTER: begin
        if (!unlocked || key_bad)  state_d = S_FAIL;
        else if (key_vld) begin
          if (cnt_last)            state_d = S_CONFIRM;
        end
        else if (tmo_end)          state_d = S_FAIL;
      end
      S_CONFIRM: begin
        if (!unlocked || key_bad)  state_d = S_FAIL;
        else if (key_vld) begin
          if (key_digit != shadow_digit) state_d = S_FAIL;
          else if (cnt_last)             state_d = S_COMMIT;
        end
        else if (tmo_end)          state_d = S_FAIL;
      end
      S_COMMIT: state_d = S_IDLE;
      S_FAIL: begin
`ifdef PSW_LOCKOUT_EN
        state_d = (fail_cnt_q == 2'd2) ? S_LOCKOUT : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
`ifdef PSW_LOCKOUT_EN
      S_LOCKOUT: begin
        if (lock_end) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      code_q   <= DEFAULT_CODE;
      shadow_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          tmo_q <= '0;
        end
        S_ENTER, S_CONFIRM: begin
          if (unlocked && key_vld) begin
            if (state_q == S_ENTER) begin
              for (int i = 0; i < CODE_LEN; i++) begin
                if (cnt_q == CNT_W'(i)) shadow_q[4*i +: 4] <= key_digit;
              end
            end
            cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
            tmo_q <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_COMMIT: code_q <= shadow_q;
        default: ;
      endcase
    end
  end

`ifdef PSW_LOCKOUT_EN
  // Consecutive-failure tracking and lockout timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_cnt_q <= 2'd0;
      lock_cnt_q <= '0;
    end else begin
      case (state_q)
        S_FAIL:   fail_cnt_q <= fail_cnt_q + 2'd1;
        S_COMMIT: fail_cnt_q <= 2'd0;
        S_LOCKOUT: begin
          if (lock_end) begin
            lock_cnt_q <= '0;
            fail_cnt_q <= 2'd0;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
`endif

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_COMMIT);
  assign err      = (state_q == S_FAIL);
  assign wr_state = state_q;

endmodule

// File: tb/tb_psw_code_writer.sv
// Randomized self-checking bench for psw_code_writer against a transaction-level code model.
module tb_psw_code_writer;
  localparam int CODE_LEN = 4;
  localparam int TIMEOUT = 16;
  localparam int LOCKOUT_CYCLES = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] sw_rise;
  logic       enroll_req;
  logic       unlocked;
  logic [2:0] rd_idx;
  logic [3:0] rd_digit;
  logic       busy, done, err;
  logic [2:0] wr_state;

  int n_chk  = 0;
  int n_pass = 0;
  int code_m[CODE_LEN];
  int fail_streak = 0;

  psw_code_writer #(
    .CODE_LEN(CODE_LEN),
    .TIMEOUT(TIMEOUT),
    .DEFAULT_CODE(16'h4321),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_rise(sw_rise),
    .enroll_req(enroll_req),
    .unlocked(unlocked),
    .rd_idx(rd_idx),
    .rd_digit(rd_digit),
    .busy(busy),
    .done(done),
    .err(err),
    .wr_state(wr_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input int d);
    sw_rise = 10'(1 << d);
    tick();
    sw_rise = '0;
  endtask

  // Idle cycles, occasionally with a stray enroll_req that must be ignored while busy.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      enroll_req = ($urandom_range(0, 3) == 0);
      tick();
      enroll_req = 1'b0;
    end
  endtask

  task automatic model_reset();
    code_m = '{1, 2, 3, 4};
    fail_streak = 0;
  endtask

  task automatic check_code(input string tag);
    for (int i = 0; i < CODE_LEN; i++) begin
      rd_idx = 3'(i);
      #1;
      check($sformatf("%s_d%0d", tag, i), int'(rd_digit), code_m[i]);
    end
  endtask

  task automatic start_enroll();
    enroll_req = 1'b1;
    tick();
    enroll_req = 1'b0;
    check("enter_state", int'(wr_state), 1);
  endtask

  // Called while err should be high; follows the failure back to IDLE (or through lockout).
  task automatic fail_tail(input string tag);
    int n;
    check({tag, "_err"}, int'(err), 1);
    check({tag, "_fstate"}, int'(wr_state), 4);
    fail_streak++;
    tick();
    check({tag, "_err_pulse"}, int'(err), 0);
`ifdef PSW_LOCKOUT_EN
    if (fail_streak == 3) begin
      check({tag, "_lockout"}, int'(wr_state), 5);
      n = 0;
      for (int i = 1; i <= LOCKOUT_CYCLES + 10; i++) begin
        if (i == 3) begin
          enroll_req = 1'b1;
          sw_rise = 10'b0000001000;
        end
        tick();
        enroll_req = 1'b0;
        sw_rise = '0;
        if (i == 3) check({tag, "_lock_hold"}, int'(wr_state), 5);
        if (!busy) begin
          n = i;
          break;
        end
      end
      check({tag, "_lock_len"}, int'(n >= LOCKOUT_CYCLES - 2 && n <= LOCKOUT_CYCLES + 2), 1);
      fail_streak = 0;
    end
`endif
    check({tag, "_idle"}, int'(busy), 0);
    check_code({tag, "_keep"});
  endtask

  // One enrolment attempt; bad_pos < 0 confirms correctly, else confirm digit bad_pos is 'wrong'.
  task automatic enroll_txn(input string tag, input int d[CODE_LEN], input int bad_pos, input int wrong);
    start_enroll();
    for (int i = 0; i < CODE_LEN; i++) begin
      key(d[i]);
      gap($urandom_range(0, 3));
    end
    check({tag, "_confirm_state"}, int'(wr_state), 2);
    for (int i = 0; i < CODE_LEN; i++) begin
      if (i == bad_pos) begin
        key(wrong);
        fail_tail(tag);
        return;
      end
      key(d[i]);
      if (i < CODE_LEN - 1) gap($urandom_range(0, 3));
    end
    check({tag, "_done"}, int'(done), 1);
    code_m = d;
    fail_streak = 0;
    tick();
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check_code({tag, "_code"});
  endtask

  initial begin
    int d[CODE_LEN];
    int first_err;
    int bp, wr;

    rst = 1'b1;
    sw_rise = '0;
    enroll_req = 1'b0;
    unlocked = 1'b1;
    rd_idx = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(wr_state), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check_code("rst_code");
    rd_idx = 3'd5;
    #1;
    check("rd_oob", int'(rd_digit), 0);

    key(3);
    key(5);
    check("idle_keys_busy", int'(busy), 0);
    check_code("idle_keys_code");

    unlocked = 1'b0;
    enroll_req = 1'b1;
    tick();
    enroll_req = 1'b0;
    check("locked_req_busy", int'(busy), 0);
    check("locked_req_err", int'(err), 0);
    unlocked = 1'b1;

    d = '{7, 0, 9, 5};
    enroll_txn("mismatch", d, 2, 8);
    enroll_txn("enrol7095", d, -1, 0);

    start_enroll();
    key(2);
    sw_rise = 10'b0000000110;
    tick();
    sw_rise = '0;
    fail_tail("badkey");

    start_enroll();
    for (int i = 0; i < CODE_LEN; i++) key(i + 1);
    first_err = 0;
    for (int i = 1; i <= TIMEOUT + 8; i++) begin
      if (err) break;
      tick();
      if (err) begin
        first_err = i;
        break;
      end
    end
    check("timeout_len", int'(first_err >= TIMEOUT - 1 && first_err <= TIMEOUT + 1), 1);
    fail_tail("timeout");

    start_enroll();
    key(1);
    key(2);
    unlocked = 1'b0;
    sw_rise = 10'b0000010000;
    tick();
    sw_rise = '0;
    fail_tail("unlock_drop");
    unlocked = 1'b1;

    d = '{6, 6, 1, 8};
    enroll_txn("enrol6618", d, -1, 0);
    start_enroll();
    for (int i = 0; i < CODE_LEN; i++) key(i);
    key(0);
    key(1);
    rst = 1'b1;
    #2;
    check("async_rst_state", int'(wr_state), 0);
    rst = 1'b0;
    model_reset();
    tick();
    check("post_rst_busy", int'(busy), 0);
    check_code("post_rst_code");

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < CODE_LEN; i++) d[i] = int'($urandom_range(0, 9));
      bp = -1;
      wr = 0;
      if ($urandom_range(0, 9) < 4) begin
        bp = int'($urandom_range(0, CODE_LEN - 1));
        wr = (d[bp] + 1 + int'($urandom_range(0, 8))) % 10;
      end
      enroll_txn($sformatf("rand%0d", t), d, bp, wr);
      gap($urandom_range(0, 2));
    end

`ifdef PSW_LOCKOUT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    d = '{3, 1, 4, 1};
    for (int k = 0; k < 3; k++) enroll_txn($sformatf("lock%0d", k), d, 0, 9);
    enroll_txn("after_lock", d, -1, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
